ascon_fin_ctrl: RTL

Sequencer for the Ascon-128a finalization phase. It accepts the 320-bit post-ciphertext state and the 128-bit key over a valid/ready handshake. It injects the key, iterates a single-round permutation datapath 12 times, and returns the 128-bit tag. In decryption mode it compares the computed tag against an expected tag and reports the result. It sits between the ciphertext-processing stage and the AXI-facing register block of the ascon_ip core.

---
 rtl/ascon_pkg.sv | 51 +++++
 rtl/ascon_round.sv | 62 ++++++
 rtl/ascon_fin_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared widths, word slices, FSM encoding and round-constant lookup for the
// Ascon finalization sequencer.
package ascon_pkg;

    localparam int unsigned STATE_W = 320;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned RC_W    = 8;
    localparam int unsigned RND_W   = 4;

    // LSB position of each 64-bit state word; x0 is the most significant.
    localparam int unsigned X0_LSB = 256;
    localparam int unsigned X1_LSB = 192;
    localparam int unsigned X2_LSB = 128;
    localparam int unsigned X3_LSB = 64;
    localparam int unsigned X4_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fin_state_e;

    // Request fields held from the accept edge until the tag is produced.
    typedef struct packed {
        logic             dec;
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] tag_exp;
    } fin_ctx_t;

    function automatic logic [RC_W-1:0] rc_lut(input logic [RND_W-1:0] rnd);
        logic [RC_W-1:0] rc;
        case (rnd)
            4'd0:    rc = 8'hf0;
            4'd1:    rc = 8'he1;
            4'd2:    rc = 8'hd2;
            4'd3:    rc = 8'hc3;
            4'd4:    rc = 8'hb4;
            4'd5:    rc = 8'ha5;
            4'd6:    rc = 8'h96;
            4'd7:    rc = 8'h87;
            4'd8:    rc = 8'h78;
            4'd9:    rc = 8'h69;
            4'd10:   rc = 8'h5a;
            4'd11:   rc = 8'h4b;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant addition, bit-sliced
// 5-bit S-box, then the per-word linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    input  logic [RC_W-1:0]    rc,
    output logic [STATE_W-1:0] s_next_c
);

    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [4:0] o;
        case (v)
            5'h00: o = 5'h04;  5'h01: o = 5'h0b;  5'h02: o = 5'h1f;  5'h03: o = 5'h14;
            5'h04: o = 5'h1a;  5'h05: o = 5'h15;  5'h06: o = 5'h09;  5'h07: o = 5'h02;
            5'h08: o = 5'h1b;  5'h09: o = 5'h05;  5'h0a: o = 5'h08;  5'h0b: o = 5'h12;
            5'h0c: o = 5'h1d;  5'h0d: o = 5'h03;  5'h0e: o = 5'h06;  5'h0f: o = 5'h1c;
            5'h10: o = 5'h1e;  5'h11: o = 5'h13;  5'h12: o = 5'h07;  5'h13: o = 5'h0e;
            5'h14: o = 5'h00;  5'h15: o = 5'h0d;  5'h16: o = 5'h11;  5'h17: o = 5'h18;
            5'h18: o = 5'h10;  5'h19: o = 5'h0c;  5'h1a: o = 5'h01;  5'h1b: o = 5'h19;
            5'h1c: o = 5'h16;  5'h1d: o = 5'h0a;  5'h1e: o = 5'h0f;  default: o = 5'h17;
        endcase
        return o;
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [WORD_W-1:0] b0, b1, b2, b3, b4;
    logic [4:0]        sb;

    always_comb begin
        a0 = s[X0_LSB +: WORD_W];
        a1 = s[X1_LSB +: WORD_W];
        a2 = s[X2_LSB +: WORD_W] ^ WORD_W'(rc);
        a3 = s[X3_LSB +: WORD_W];
        a4 = s[X4_LSB +: WORD_W];
        b0 = '0;
        b1 = '0;
        b2 = '0;
        b3 = '0;
        b4 = '0;
        sb = '0;
        // Bit slice i gathers bit i of every word, x0 as the S-box MSB.
        for (int i = 0; i < WORD_W; i++) begin
            sb    = sbox({a0[i], a1[i], a2[i], a3[i], a4[i]});
            b0[i] = sb[4];
            b1[i] = sb[3];
            b2[i] = sb[2];
            b3[i] = sb[1];
            b4[i] = sb[0];
        end
        s_next_c = {b0 ^ ror(b0, 19) ^ ror(b0, 28),
                    b1 ^ ror(b1, 61) ^ ror(b1, 39),
                    b2 ^ ror(b2, 1)  ^ ror(b2, 6),
                    b3 ^ ror(b3, 10) ^ ror(b3, 17),
                    b4 ^ ror(b4, 7)  ^ ror(b4, 41)};
    end

endmodule

// File: rtl/ascon_fin_ctrl.sv
// Ascon-128a finalization sequencer: key injection, 12 single-round
// iterations, tag output or tag verification over valid/ready handshakes.
module ascon_fin_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [KEY_W-1:0]   in_key,
    input  logic               in_dec,
    input  logic [KEY_W-1:0]   in_tag_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [KEY_W-1:0]   out_tag,
    output logic               out_tag_ok,
    output logic               busy
);

    fin_state_e         state_q, state_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    fin_ctx_t           ctx_q, ctx_d;
    logic [KEY_W-1:0]   out_tag_d;
    logic               tag_ok_d;

    logic [RC_W-1:0]    rc_c;
    logic [STATE_W-1:0] r_next_c;
    logic [KEY_W-1:0]   tag_c;

    assign rc_c = rc_lut(rnd_q);

    ascon_round u_round (
        .s        (s_q),
        .rc       (rc_c),
        .s_next_c (r_next_c)
    );

    // Tag as it will stand once the final round is written back.
    assign tag_c = r_next_c[KEY_W-1:0] ^ ctx_q.key;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        rnd_d     = rnd_q;
        ctx_d     = ctx_q;
        out_tag_d = out_tag;
        tag_ok_d  = out_tag_ok;

        if (clr) begin
            state_d   = IDLE;
            s_d       = '0;
            rnd_d     = '0;
            ctx_d     = '0;
            out_tag_d = '0;
            tag_ok_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_d                   = in_state;
                        s_d[X3_LSB +: KEY_W]  = in_state[X3_LSB +: KEY_W] ^ in_key;
                        ctx_d.dec             = in_dec;
                        ctx_d.key             = in_key;
                        ctx_d.tag_exp         = in_tag_exp;
                        rnd_d                 = '0;
                        state_d               = RUN;
                    end
                end
                RUN: begin
                    s_d = r_next_c;
                    if (rnd_q == RND_W'(ROUNDS - 1)) begin
                        rnd_d     = '0;
                        state_d   = DONE;
                        out_tag_d = ctx_q.dec ? '0 : tag_c;
                        tag_ok_d  = ctx_q.dec & (tag_c == ctx_q.tag_exp);
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d   = IDLE;
                        out_tag_d = '0;
                        tag_ok_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake flags are registered from the next state, so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            rnd_q      <= '0;
            ctx_q      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_tag    <= '0;
            out_tag_ok <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            rnd_q      <= rnd_d;
            ctx_q      <= ctx_d;
            in_ready   <= (state_d == IDLE);
            out_valid  <= (state_d == DONE);
            busy       <= (state_d != IDLE);
            out_tag    <= out_tag_d;
            out_tag_ok <= tag_ok_d;
        end
    end

endmodule
